sp_ram_banked_arb: RTL and testbench

- Parametrised successor to the single-port RAM wrapper.
- Word-interleaved multi-bank SRAM shared by NUM_PORTS masters.
- Per-bank round-robin arbitration with req/gnt/rvalid handshake, byte-enabled writes, fixed 1-cycle response latency.
- Sits between core instruction/data/accelerator ports and on-chip memory; lets conflict-free accesses proceed in parallel.

---
 rtl/sp_ram_banked_arb.sv | 136 +++++++++++++
 tb/tb_sp_ram_banked_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_banked_arb.sv
// Word-interleaved multi-bank SRAM shared by NUM_PORTS masters.
// Each bank has its own round-robin arbiter; every granted access responds one cycle later.
module sp_ram_banked_arb #(
   parameter int unsigned RAM_SIZE   = 32768,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
   input  logic                              clk,
   input  logic                              rstn_i,
   input  logic [NUM_PORTS-1:0]              req_i,
   output logic [NUM_PORTS-1:0]              gnt_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]              rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o
);

   localparam int unsigned BE_W      = DATA_WIDTH / 8;
   localparam int unsigned OFS       = (BE_W > 1) ? $clog2(BE_W) : 0;
   localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
   localparam int unsigned BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int unsigned DEPTH     = RAM_SIZE / BE_W / NUM_BANKS;
   localparam int unsigned ROW_W     = $clog2(DEPTH);
   localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [BSEL_W-1:0]     w_bank [NUM_PORTS];
   logic [ROW_W-1:0]      w_row  [NUM_PORTS];

   logic [PTR_W-1:0]      r_ptr  [NUM_BANKS];
   logic [NUM_BANKS-1:0]  w_bgnt;
   logic [PTR_W-1:0]      w_bport [NUM_BANKS];
   logic [ROW_W-1:0]      w_row_b [NUM_BANKS];
   logic [NUM_BANKS-1:0]  w_we_b;
   logic [BE_W-1:0]       w_be_b  [NUM_BANKS];
   logic [DATA_WIDTH-1:0] w_wd_b  [NUM_BANKS];
   logic [NUM_PORTS-1:0]  w_gnt;

   logic [DATA_WIDTH-1:0] r_mem     [NUM_BANKS][DEPTH];
   logic [DATA_WIDTH-1:0] r_bank_rd [NUM_BANKS];
   logic [NUM_PORTS-1:0]  r_rvalid;
   logic [NUM_PORTS-1:0]  r_isrd;
   logic [BSEL_W-1:0]     r_rbank [NUM_PORTS];

   // Sub-word offset bits never take part in decode.
   logic w_unused;
   assign w_unused = ^addr_i;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
      logic [ADDR_WIDTH-1:0] w_addr;
      assign w_addr = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (NUM_BANKS > 1) begin : g_bank
         assign w_bank[p] = w_addr[OFS +: BANK_BITS];
      end else begin : g_one
         assign w_bank[p] = '0;
      end
      assign w_row[p] = w_addr[OFS+BANK_BITS +: ROW_W];
   end

   always_comb begin
      int unsigned idx;
      w_gnt  = '0;
      w_bgnt = '0;
      w_we_b = '0;
      idx    = 0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         w_bport[b] = '0;
         w_row_b[b] = '0;
         w_be_b[b]  = '0;
         w_wd_b[b]  = '0;
      end
      // Scan starts at the bank pointer and wraps; a port decodes to one bank only.
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(r_ptr[b]) + k) % NUM_PORTS;
            if (rstn_i && !w_bgnt[b] && req_i[idx] && (w_bank[idx] == BSEL_W'(b))) begin
               w_bgnt[b]  = 1'b1;
               w_bport[b] = PTR_W'(idx);
               w_gnt[idx] = 1'b1;
            end
         end
         if (w_bgnt[b]) begin
            w_row_b[b] = w_row[w_bport[b]];
            w_we_b[b]  = we_i[w_bport[b]];
            w_be_b[b]  = be_i[32'(w_bport[b])*BE_W +: BE_W];
            w_wd_b[b]  = wdata_i[32'(w_bport[b])*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign gnt_o = w_gnt;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) r_rbank[p] <= '0;
         r_rvalid <= '0;
         r_isrd   <= '0;
      end else begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (w_bgnt[b]) r_ptr[b] <= PTR_W'((32'(w_bport[b]) + 1) % NUM_PORTS);
         end
         for (int unsigned p = 0; p < NUM_PORTS; p++) r_rbank[p] <= w_bank[p];
         r_rvalid <= w_gnt;
         r_isrd   <= w_gnt & ~we_i;
      end
   end

   // Storage is not reset; write and read share the bank's single access slot.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (w_bgnt[b]) begin
            if (w_we_b[b]) begin
               for (int unsigned i = 0; i < BE_W; i++) begin
                  if (w_be_b[b][i]) r_mem[b][w_row_b[b]][i*8 +: 8] <= w_wd_b[b][i*8 +: 8];
               end
            end else begin
               r_bank_rd[b] <= r_mem[b][w_row_b[b]];
            end
         end
      end
   end

   assign rvalid_o = r_rvalid;

   always_comb begin
      rdata_o = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (r_rvalid[p] && r_isrd[p]) rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_bank_rd[r_rbank[p]];
      end
   end

endmodule

// File: tb/tb_sp_ram_banked_arb.sv
// Directed bench for sp_ram_banked_arb: default 4-bank/2-port instance plus a
// single-bank/3-port instance for the wrap-around arbitration case.
module tb_sp_ram_banked_arb;

   logic        clk;
   logic        rstn;

   logic [1:0]  req, gnt, we, rvalid;
   logic [29:0] addr;
   logic [7:0]  be;
   logic [63:0] wdata, rdata;

   logic [2:0]  req2, gnt2, we2, rvalid2;
   logic [17:0] addr2;
   logic [11:0] be2;
   logic [95:0] wdata2, rdata2;

   int n_vec = 0;
   int n_err = 0;

   sp_ram_banked_arb u_dut (
      .clk(clk), .rstn_i(rstn), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata)
   );

   sp_ram_banked_arb #(.RAM_SIZE(64), .DATA_WIDTH(32), .NUM_BANKS(1), .NUM_PORTS(3)) u_dut3 (
      .clk(clk), .rstn_i(rstn), .req_i(req2), .gnt_o(gnt2), .addr_i(addr2), .we_i(we2),
      .be_i(be2), .wdata_i(wdata2), .rvalid_o(rvalid2), .rdata_o(rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drv(input int p, input logic r, input logic [14:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d);
      req[p] = r;
      addr[p*15 +: 15] = a;
      we[p] = w;
      be[p*4 +: 4] = b;
      wdata[p*32 +: 32] = d;
   endtask

   task automatic drv2(input int p, input logic r, input logic [5:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
      req2[p] = r;
      addr2[p*6 +: 6] = a;
      we2[p] = w;
      be2[p*4 +: 4] = b;
      wdata2[p*32 +: 32] = d;
   endtask

   task automatic idle();
      req  = '0;
      req2 = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      addr = '0; we = '0; be = '0; wdata = '0;
      addr2 = '0; we2 = '0; be2 = '0; wdata2 = '0;
      req = 2'b11; req2 = 3'b111;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt got %b exp 00", gnt); end
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rst_rvalid got %b exp 00", rvalid); end
      n_vec++; if (rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", rdata); end
      n_vec++; if (gnt2 !== 3'b000) begin n_err++; $display("FAIL rst_gnt3 got %b exp 000", gnt2); end
      n_vec++; if (rvalid2 !== 3'b000) begin n_err++; $display("FAIL rst_rvalid3 got %b exp 000", rvalid2); end
      idle();
      rstn = 1'b1;
      tick();
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rst_rel_rvalid got %b exp 00", rvalid); end
   endtask

   task automatic test_write_read();
      drv(0, 1'b1, 15'h0010, 1'b1, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL wr_gnt got %b exp 01", gnt); end
      tick();
      n_vec++; if (rvalid !== 2'b01) begin n_err++; $display("FAIL wr_rvalid got %b exp 01", rvalid); end
      n_vec++; if (rdata !== 64'h0) begin n_err++; $display("FAIL wr_rdata got %h exp 0", rdata); end
      drv(0, 1'b0, 15'h0, 1'b0, 4'h0, 32'h0);
      drv(1, 1'b1, 15'h0010, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rd_gnt got %b exp 10", gnt); end
      tick();
      n_vec++; if (rvalid !== 2'b10) begin n_err++; $display("FAIL rd_rvalid got %b exp 10", rvalid); end
      n_vec++; if (rdata !== {32'hDEADBEEF, 32'h0}) begin n_err++; $display("FAIL rd_rdata got %h exp deadbeef_00000000", rdata); end
      idle();
   endtask

   task automatic test_partial_write();
      drv(0, 1'b1, 15'h0010, 1'b1, 4'b0101, 32'h11223344);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL pw_gnt got %b exp 01", gnt); end
      tick();
      n_vec++; if (rvalid !== 2'b01) begin n_err++; $display("FAIL pw_rvalid got %b exp 01", rvalid); end
      drv(0, 1'b1, 15'h0010, 1'b0, 4'h0, 32'h0);
      tick();
      n_vec++; if (rdata !== {32'h0, 32'hDE22BE44}) begin n_err++; $display("FAIL pw_rdata got %h exp de22be44", rdata); end
      idle();
   endtask

   task automatic test_conflict();
      logic [1:0]  eg  [4];
      logic [63:0] erd [4];
      eg  = '{2'b01, 2'b10, 2'b01, 2'b10};
      erd = '{{32'h0, 32'hA0A0A0A0}, {32'hB1B1B1B1, 32'h0}, {32'h0, 32'hA0A0A0A0}, {32'hB1B1B1B1, 32'h0}};
      // Preload; these accesses also return bank0's pointer to port 0.
      drv(0, 1'b1, 15'h0000, 1'b1, 4'hF, 32'hA0A0A0A0);
      drv(1, 1'b1, 15'h0004, 1'b1, 4'hF, 32'hC2C2C2C2);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b11) begin n_err++; $display("FAIL pre_gnt got %b exp 11", gnt); end
      tick();
      drv(0, 1'b0, 15'h0, 1'b0, 4'h0, 32'h0);
      drv(1, 1'b1, 15'h0040, 1'b1, 4'hF, 32'hB1B1B1B1);
      tick();
      drv(0, 1'b1, 15'h0000, 1'b0, 4'h0, 32'h0);
      drv(1, 1'b1, 15'h0040, 1'b0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++; if (gnt !== eg[i]) begin n_err++; $display("FAIL cf_gnt[%0d] got %b exp %b", i, gnt, eg[i]); end
         tick();
         n_vec++; if (rvalid !== eg[i]) begin n_err++; $display("FAIL cf_rvalid[%0d] got %b exp %b", i, rvalid, eg[i]); end
         n_vec++; if (rdata !== erd[i]) begin n_err++; $display("FAIL cf_rdata[%0d] got %h exp %h", i, rdata, erd[i]); end
      end
      idle();
   endtask

   task automatic test_no_conflict();
      drv(0, 1'b1, 15'h0000, 1'b0, 4'h0, 32'h0);
      drv(1, 1'b1, 15'h0004, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b11) begin n_err++; $display("FAIL nc_gnt got %b exp 11", gnt); end
      tick();
      n_vec++; if (rvalid !== 2'b11) begin n_err++; $display("FAIL nc_rvalid got %b exp 11", rvalid); end
      n_vec++; if (rdata !== {32'hC2C2C2C2, 32'hA0A0A0A0}) begin n_err++; $display("FAIL nc_rdata got %h exp c2c2c2c2a0a0a0a0", rdata); end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [14:0] ta [5];
      logic        tw [5];
      logic [3:0]  tb [5];
      logic [31:0] te [5];
      ta = '{15'h0004, 15'h0004, 15'h0010, 15'h0040, 15'h0000};
      tw = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tb = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      te = '{32'h0, 32'hC2C2C2C2, 32'hDE22BE44, 32'hB1B1B1B1, 32'hA0A0A0A0};
      for (int i = 0; i < 5; i++) begin
         drv(0, 1'b1, ta[i], tw[i], tb[i], 32'hFFFFFFFF);
         @(negedge clk);
         n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL b2b_gnt[%0d] got %b exp 01", i, gnt); end
         tick();
         n_vec++; if (rvalid !== 2'b01) begin n_err++; $display("FAIL b2b_rvalid[%0d] got %b exp 01", i, rvalid); end
         n_vec++; if (rdata !== {32'h0, te[i]}) begin n_err++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rdata, te[i]); end
      end
      idle();
      tick();
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL b2b_idle_rvalid got %b exp 00", rvalid); end
      n_vec++; if (rdata !== 64'h0) begin n_err++; $display("FAIL b2b_idle_rdata got %h exp 0", rdata); end
   endtask

   task automatic test_reset_mid();
      drv(0, 1'b1, 15'h0000, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rm_gnt got %b exp 01", gnt); end
      tick();
      n_vec++; if (rdata !== {32'h0, 32'hA0A0A0A0}) begin n_err++; $display("FAIL rm_pre_rdata got %h exp a0a0a0a0", rdata); end
      drv(1, 1'b1, 15'h0040, 1'b0, 4'h0, 32'h0);
      rstn = 1'b0;
      #1;
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rm_rvalid got %b exp 00", rvalid); end
      n_vec++; if (rdata !== 64'h0) begin n_err++; $display("FAIL rm_rdata got %h exp 0", rdata); end
      n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rm_gnt_rst got %b exp 00", gnt); end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      // Bank0 pointer was 1 before reset; a cleared pointer picks port 0.
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rm_ptr_gnt got %b exp 01", gnt); end
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rm_rel_rvalid got %b exp 00", rvalid); end
      tick();
      n_vec++; if (rdata !== {32'h0, 32'hA0A0A0A0}) begin n_err++; $display("FAIL rm_keep0 got %h exp a0a0a0a0", rdata); end
      drv(0, 1'b0, 15'h0, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rm_gnt1 got %b exp 10", gnt); end
      tick();
      n_vec++; if (rdata !== {32'hB1B1B1B1, 32'h0}) begin n_err++; $display("FAIL rm_keep1 got %h exp b1b1b1b1_00000000", rdata); end
      idle();
   endtask

   task automatic test_sweep_1bank_3port();
      logic [31:0] vals [3];
      logic [95:0] erd;
      vals = '{32'h11111111, 32'h22222222, 32'h33333333};
      for (int p = 0; p < 3; p++) drv2(p, 1'b1, 6'(p*4), 1'b1, 4'hF, vals[p]);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (gnt2 !== 3'(1 << k)) begin n_err++; $display("FAIL sw_wgnt[%0d] got %b exp %b", k, gnt2, 3'(1 << k)); end
         tick();
         n_vec++; if (rvalid2 !== 3'(1 << k)) begin n_err++; $display("FAIL sw_wrvalid[%0d] got %b exp %b", k, rvalid2, 3'(1 << k)); end
         req2[k] = 1'b0;
      end
      for (int p = 0; p < 3; p++) drv2(p, 1'b1, 6'(p*4), 1'b0, 4'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (gnt2 !== 3'(1 << k)) begin n_err++; $display("FAIL sw_rgnt[%0d] got %b exp %b", k, gnt2, 3'(1 << k)); end
         tick();
         erd = '0;
         erd[k*32 +: 32] = vals[k];
         n_vec++; if (rdata2 !== erd) begin n_err++; $display("FAIL sw_rdata[%0d] got %h exp %h", k, rdata2, erd); end
         req2[k] = 1'b0;
      end
      req2 = 3'b111;
      @(negedge clk);
      n_vec++; if (gnt2 !== 3'b001) begin n_err++; $display("FAIL sw_wrap_gnt got %b exp 001", gnt2); end
      tick();
      n_vec++; if (rdata2 !== {64'h0, 32'h11111111}) begin n_err++; $display("FAIL sw_wrap_rdata got %h exp 11111111", rdata2); end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial_write();
      test_conflict();
      test_no_conflict();
      test_back_to_back();
      test_reset_mid();
      test_sweep_1bank_3port();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
